// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-port SDRAM request arbiter: FSM states, port ids,
// the SDRAM address layout and the registered command word.
package sdram_arb_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    GAP     = 2'd3
  } state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // Address layout seen by SDRAM_Interface.
  typedef struct packed {
    logic [1:0]  bank;
    logic [7:0]  col;
    logic [11:0] row;
  } sdram_addr_t;

  typedef struct packed {
    logic              wnr;
    sdram_addr_t       addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner select for the arbiter: port 0 has fixed priority, port 1 overrides
// once it has waited MAX_WAIT cycles while requesting.
module sdram_arb_pick
  import sdram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic  Clk,
  input  logic  Reset_N,
  input  logic  P0_Req,
  input  logic  P1_Req,
  input  logic  Arb_Go,
  output port_e Winner
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0] wait_cnt;
  logic       starving;

  assign starving = P1_Req && (wait_cnt >= MAX_WAIT_C);
  assign Winner   = (starving || (P1_Req && !P0_Req)) ? PORT1 : PORT0;

  // Saturating count of cycles port 1 has been kept waiting.
  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      wait_cnt <= '0;
    end else if (!P1_Req || (Arb_Go && Winner == PORT1)) begin
      wait_cnt <= '0;
    end else if (wait_cnt != 8'hFF) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the single SDRAM_Interface request port between the ADC writer
// (port 0) and the host readback (port 1); flags a stalled controller on Err.
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int READ_LAT    = 2,
  parameter int MAX_WAIT    = 64,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic              Clk,
  input  logic              Reset_N,
  input  logic              P0_Req,
  input  logic              P0_WnR,
  input  logic [ADDR_W-1:0] P0_Address,
  input  logic [DATA_W-1:0] P0_DataIn,
  output logic              P0_Ack,
  output logic              P0_RdValid,
  input  logic              P1_Req,
  input  logic              P1_WnR,
  input  logic [ADDR_W-1:0] P1_Address,
  input  logic [DATA_W-1:0] P1_DataIn,
  output logic              P1_Ack,
  output logic              P1_RdValid,
  output logic [DATA_W-1:0] RdData,
  output logic              Mem_Req,
  output logic              Mem_WnR,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_DataIn,
  input  logic [DATA_W-1:0] Mem_DataOut,
  input  logic              Mem_Busy,
  input  logic              Mem_Ack,
  output logic              Grant,
  output logic              Err
);

  localparam logic [3:0]  LAT_LOAD = 4'(READ_LAT - 1);
  localparam logic [15:0] TO_LAST  = 16'(ACK_TIMEOUT - 1);

  state_e            state_q, state_d;
  port_e             grant_q, winner;
  cmd_t              cmd_q, p0_cmd, p1_cmd;
  logic              mem_req_q, mem_req_d;
  logic [3:0]        lat_q;
  logic [15:0]       to_q;
  logic              err_q;
  logic              p0_ack_q, p1_ack_q, p0_rdv_q, p1_rdv_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              arb_go, ack_take, timeout, rd_done, bad_state;

  assign p0_cmd = {P0_WnR, P0_Address, P0_DataIn};
  assign p1_cmd = {P1_WnR, P1_Address, P1_DataIn};

  sdram_arb_pick #(.MAX_WAIT(MAX_WAIT)) u_pick (
    .Clk     (Clk),
    .Reset_N (Reset_N),
    .P0_Req  (P0_Req),
    .P1_Req  (P1_Req),
    .Arb_Go  (arb_go),
    .Winner  (winner)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge Clk) begin
    if (!Reset_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arb_go) state_d = ISSUE;
      ISSUE: begin
        if (ack_take)     state_d = cmd_q.wnr ? GAP : WAIT_RD;
        else if (timeout) state_d = GAP;
      end
      WAIT_RD: if (rd_done) state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    arb_go    = 1'b0;
    ack_take  = 1'b0;
    timeout   = 1'b0;
    rd_done   = 1'b0;
    bad_state = 1'b0;
    mem_req_d = 1'b0;
    case (state_q)
      IDLE: begin
        arb_go    = !Mem_Busy && (P0_Req || P1_Req);
        mem_req_d = arb_go;
      end
      ISSUE: begin
        ack_take  = Mem_Ack;
        timeout   = !Mem_Ack && (to_q == TO_LAST);
        mem_req_d = !Mem_Ack && !timeout;
      end
      WAIT_RD: rd_done = (lat_q == 4'd0);
      GAP:     ;
      default: bad_state = 1'b1;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_N) begin
      grant_q   <= PORT0;
      cmd_q     <= '0;
      mem_req_q <= 1'b0;
      lat_q     <= '0;
      to_q      <= '0;
      err_q     <= 1'b0;
      p0_ack_q  <= 1'b0;
      p1_ack_q  <= 1'b0;
      p0_rdv_q  <= 1'b0;
      p1_rdv_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      mem_req_q <= mem_req_d;
      p0_ack_q  <= ack_take && (grant_q == PORT0);
      p1_ack_q  <= ack_take && (grant_q == PORT1);
      p0_rdv_q  <= rd_done && (grant_q == PORT0);
      p1_rdv_q  <= rd_done && (grant_q == PORT1);

      if (arb_go) begin
        grant_q <= winner;
        cmd_q   <= (winner == PORT1) ? p1_cmd : p0_cmd;
        to_q    <= '0;
      end else if (state_q == ISSUE) begin
        to_q <= to_q + 16'd1;
      end

      if (ack_take)                              lat_q <= LAT_LOAD;
      else if (state_q == WAIT_RD && !rd_done)   lat_q <= lat_q - 4'd1;

      if (rd_done)               rd_data_q <= Mem_DataOut;
      if (timeout || bad_state)  err_q     <= 1'b1;
    end
  end

  assign Mem_Req     = mem_req_q;
  assign Mem_WnR     = cmd_q.wnr;
  assign Mem_Address = cmd_q.addr;
  assign Mem_DataIn  = cmd_q.data;
  assign Grant       = grant_q;
  assign Err         = err_q;
  assign P0_Ack      = p0_ack_q;
  assign P1_Ack      = p1_ack_q;
  assign P0_RdValid  = p0_rdv_q;
  assign P1_RdValid  = p1_rdv_q;
  assign RdData      = rd_data_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a registered ideal-controller model.
module tb_sdram_port_arbiter;

  localparam int READ_LAT    = 2;
  localparam int MAX_WAIT    = 4;
  localparam int ACK_TIMEOUT = 16;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        P0_Req, P0_WnR, P1_Req, P1_WnR;
  logic [21:0] P0_Address, P1_Address;
  logic [15:0] P0_DataIn, P1_DataIn;
  logic        P0_Ack, P0_RdValid, P1_Ack, P1_RdValid;
  logic [15:0] RdData;
  logic        Mem_Req, Mem_WnR;
  logic [21:0] Mem_Address;
  logic [15:0] Mem_DataIn, Mem_DataOut;
  logic        Mem_Busy, Mem_Ack;
  logic        Grant, Err;

  logic        model_ack_en;
  logic [15:0] model_word;
  logic [15:0] ack_sr;

  int n_cmp = 0;
  int n_bad = 0;

  sdram_port_arbiter #(
    .READ_LAT    (READ_LAT),
    .MAX_WAIT    (MAX_WAIT),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .Clk         (Clk),
    .Reset_N     (Reset_N),
    .P0_Req      (P0_Req),
    .P0_WnR      (P0_WnR),
    .P0_Address  (P0_Address),
    .P0_DataIn   (P0_DataIn),
    .P0_Ack      (P0_Ack),
    .P0_RdValid  (P0_RdValid),
    .P1_Req      (P1_Req),
    .P1_WnR      (P1_WnR),
    .P1_Address  (P1_Address),
    .P1_DataIn   (P1_DataIn),
    .P1_Ack      (P1_Ack),
    .P1_RdValid  (P1_RdValid),
    .RdData      (RdData),
    .Mem_Req     (Mem_Req),
    .Mem_WnR     (Mem_WnR),
    .Mem_Address (Mem_Address),
    .Mem_DataIn  (Mem_DataIn),
    .Mem_DataOut (Mem_DataOut),
    .Mem_Busy    (Mem_Busy),
    .Mem_Ack     (Mem_Ack),
    .Grant       (Grant),
    .Err         (Err)
  );

  always #5 Clk = ~Clk;

  // Controller model: registered one-cycle Ack per request, read word on
  // DataOut for exactly one cycle, READ_LAT cycles after Ack.
  always @(posedge Clk) begin
    if (!Reset_N) begin
      Mem_Ack <= 1'b0;
      ack_sr  <= '0;
    end else begin
      Mem_Ack <= model_ack_en && Mem_Req && !Mem_Ack;
      ack_sr  <= {ack_sr[14:0], Mem_Ack};
    end
  end
  assign Mem_DataOut = ack_sr[READ_LAT-1] ? model_word : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  initial begin
    logic seen;
    logic prev;
    int   rises;

    Reset_N = 1'b0; Mem_Busy = 1'b0; model_ack_en = 1'b1; model_word = 16'h0000;
    P0_Req = 0; P0_WnR = 0; P0_Address = '0; P0_DataIn = '0;
    P1_Req = 0; P1_WnR = 0; P1_Address = '0; P1_DataIn = '0;
    tick(3);
    check("rst_mem_req", Mem_Req, 0);
    check("rst_grant", Grant, 0);
    check("rst_err", Err, 0);
    check("rst_rddata", RdData, 0);
    check("rst_acks", {P0_Ack, P1_Ack, P0_RdValid, P1_RdValid}, 0);
    Reset_N = 1'b1;
    tick(2);

    // 1: port 0 write
    P0_Req = 1; P0_WnR = 1; P0_Address = 22'h012345; P0_DataIn = 16'hBEEF;
    tick();
    check("t1_mem_req_c1", Mem_Req, 1);
    check("t1_mem_wnr", Mem_WnR, 1);
    check("t1_mem_addr", Mem_Address, 22'h012345);
    check("t1_mem_data", Mem_DataIn, 16'hBEEF);
    check("t1_grant", Grant, 0);
    tick();
    check("t1_ack_c2", P0_Ack, 0);
    tick();
    check("t1_ack_c3", P0_Ack, 1);
    check("t1_req_drop", Mem_Req, 0);
    P0_Req = 0;
    tick();
    check("t1_ack_pulse", P0_Ack, 0);
    tick();

    // 2: port 1 read
    P1_Req = 1; P1_WnR = 0; P1_Address = 22'h2ABCDE; model_word = 16'h1234;
    tick();
    check("t2_grant", Grant, 1);
    check("t2_mem_wnr", Mem_WnR, 0);
    check("t2_mem_addr", Mem_Address, 22'h2ABCDE);
    tick(2);
    check("t2_p1_ack", P1_Ack, 1);
    P1_Req = 0;
    tick();
    check("t2_rdv_early", P1_RdValid, 0);
    tick();
    check("t2_rdv", P1_RdValid, 1);
    check("t2_p0_rdv", P0_RdValid, 0);
    check("t2_rddata", RdData, 16'h1234);
    check("t2_no_mem_ack", Mem_Ack, 0);
    tick();
    check("t2_rdv_pulse", P1_RdValid, 0);
    check("t2_rddata_hold", RdData, 16'h1234);

    // 3: both ports hold requests; port 1 overrides after 4 waiting cycles
    P0_Req = 1; P0_WnR = 1; P0_Address = 22'h000111; P0_DataIn = 16'h1111;
    P1_Req = 1; P1_WnR = 1; P1_Address = 22'h3F0222; P1_DataIn = 16'h2222;
    prev = Mem_Req; rises = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (Mem_Req && !prev) rises++;
      prev = Mem_Req;
      if (i == 1) begin
        check("t3_grant_c1", Grant, 0);
        check("t3_addr_c1", Mem_Address, 22'h000111);
      end
      if (i == 3) check("t3_p0_ack_c3", P0_Ack, 1);
      if (i == 5) begin
        check("t3_grant_c5", Grant, 1);
        check("t3_addr_c5", Mem_Address, 22'h3F0222);
        check("t3_data_c5", Mem_DataIn, 16'h2222);
      end
      if (i == 7) check("t3_p1_ack_c7", P1_Ack, 1);
      if (i == 9) check("t3_grant_c9", Grant, 0);
    end
    check("t3_issue_count", rises, 3);
    P0_Req = 0; P1_Req = 0;
    tick(2);

    // 4: busy controller holds off the grant
    Mem_Busy = 1; P0_Req = 1; P0_WnR = 1; P0_Address = 22'h155555; P0_DataIn = 16'h5A5A;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (Mem_Req) seen = 1;
    end
    check("t4_busy_hold", seen, 0);
    Mem_Busy = 0;
    tick();
    check("t4_issue_after_busy", Mem_Req, 1);
    check("t4_data", Mem_DataIn, 16'h5A5A);
    tick(2);
    check("t4_ack", P0_Ack, 1);
    P0_Req = 0;
    tick(2);

    // 5: controller never acks
    model_ack_en = 0;
    P0_Req = 1; P0_WnR = 1; P0_Address = 22'h0ABCDE; P0_DataIn = 16'h7777;
    tick();
    check("t5_issue", Mem_Req, 1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!Mem_Req || Err || P0_Ack) seen = 1;
    end
    check("t5_hold_15", seen, 0);
    tick();
    check("t5_err", Err, 1);
    check("t5_req_drop", Mem_Req, 0);
    check("t5_no_ack", P0_Ack, 0);
    tick();
    check("t5_gap", Mem_Req, 0);
    model_ack_en = 1;
    tick();
    check("t5_retry", Mem_Req, 1);
    check("t5_retry_grant", Grant, 0);
    tick(2);
    check("t5_retry_ack", P0_Ack, 1);
    check("t5_err_sticky", Err, 1);
    P0_Req = 0;
    tick(2);

    // 6: reset while waiting for read data
    P1_Req = 1; P1_WnR = 0; P1_Address = 22'h1F00F0; model_word = 16'hCAFE;
    tick(3);
    check("t6_p1_ack", P1_Ack, 1);
    P1_Req = 0;
    Reset_N = 0;
    tick();
    check("t6_rst_req", Mem_Req, 0);
    check("t6_rst_outs", {Grant, Err, Mem_WnR, P0_Ack, P1_Ack, P0_RdValid, P1_RdValid}, 0);
    check("t6_rst_addr", Mem_Address, 0);
    check("t6_rst_data", {Mem_DataIn, RdData}, 0);
    Reset_N = 1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (P1_RdValid || P0_RdValid) seen = 1;
    end
    check("t6_no_rdvalid", seen, 0);
    P0_Req = 1; P0_WnR = 1; P0_Address = 22'h000042; P0_DataIn = 16'h4242;
    tick();
    check("t6_fresh_req", Mem_Req, 1);
    check("t6_fresh_data", Mem_DataIn, 16'h4242);
    tick(2);
    check("t6_fresh_ack", P0_Ack, 1);
    P0_Req = 0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
